voice_sched: RTL and testbench
==============================

Name: voice_sched

Overview:
- Per-sample voice scheduler. On each 48 kHz sample-rate trigger it walks all voice slots in order and issues a start/index pulse to one shared sample generator.
- It waits for each generated sample, accumulates the samples into a saturated mono mix, and emits one mix word per sample period.
- It sits between the sample-rate trigger source and the shared voice datapath, feeding the output/DAC path.

Parameters:
- NUM_VOICES, 8, number of voice slots serviced per sample period (2..16).
- IDX_W, 3, width of the voice index; must satisfy 2**IDX_W >= NUM_VOICES.
- SMPL_W, 16, signed sample width of the generator output and of the mix.
- TIMEOUT_CYC, 255, maximum cycles spent waiting for gen_done (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- smpl_rate_trig  in  1  one-cycle sample-rate pulse.
- voice_en  in  NUM_VOICES  per-voice enable mask; bit i is sampled when slot i is reached.
- gen_start  out  1  one-cycle start pulse to the shared generator.
- gen_voice  out  IDX_W  voice index; valid while gen_start is high and held until gen_done.
- gen_done  in  1  generator result strobe.
- gen_sample  in  SMPL_W  signed generator result; valid with gen_done.
- mix_out  out  SMPL_W  signed saturated mix.
- mix_valid  out  1  one-cycle strobe marking mix_out as new.
- busy  out  1  high in every state except IDLE.
- ovr_flag  out  1  sticky: a trigger arrived while busy.
- ovr_clr  in  1  clears ovr_flag.
- timeout_err  out  1  sticky voice-timeout flag; tied 0 when the feature is out.

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - State goes to IDLE; idx = 0; acc = 0.
  - gen_start = 0, gen_voice = 0, mix_out = 0, mix_valid = 0, ovr_flag = 0, timeout_err = 0.
  - Reset mid-frame abandons the frame: no mix_valid, and any gen_done arriving later is ignored.
- Accumulator: acc is SMPL_W+IDX_W bits, signed. Each gen_sample is sign-extended before it is added.
- States:
  - IDLE: on smpl_rate_trig, clear acc, set idx = 0, go to START.
  - START, voice_en[idx] = 1: drive gen_start = 1 and gen_voice = idx for exactly one cycle; go to WAIT.
  - START, voice_en[idx] = 0: no gen_start; the voice contributes 0; go to ADV.
  - WAIT: gen_start = 0, gen_voice held. On gen_done: acc += gen_sample; go to ADV. gen_done seen in the same cycle as gen_start is not possible, since WAIT begins the cycle after.
  - ADV: if idx == NUM_VOICES-1, go to OUT; else idx += 1 and go to START.
  - OUT: mix_out = acc clipped to [-2**(SMPL_W-1), 2**(SMPL_W-1)-1]; mix_valid = 1 for this cycle only; go to IDLE.
- mix_out holds its value until the next OUT.
- Latency, all voices enabled and gen_done one cycle after gen_start:
  - Trigger sampled at edge T gives mix_valid in cycle T + 3*NUM_VOICES + 1 (T+25 for 8 voices).
  - Each disabled voice costs 2 cycles instead of 3.
- gen_done outside WAIT is ignored, with no accumulation.
- smpl_rate_trig while busy: the trigger is dropped and ovr_flag is set. The frame in progress continues unaffected.
- ovr_clr clears ovr_flag. If ovr_clr and an overrun happen in the same cycle, set wins.
- All voices disabled: the frame still runs and mix_out = 0 with mix_valid asserted.
- smpl_rate_trig in the same cycle as the OUT state is treated as busy: dropped, and overrun is flagged.

Optional Feature:
- Macro: VOICE_SCHED_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle without gen_done.
  - When it reaches TIMEOUT_CYC, the voice contributes 0, timeout_err is set (sticky, cleared only by reset), and the FSM goes to ADV.
  - A gen_done arriving in that same cycle takes priority: the sample is accumulated and no error is raised.
- Undefined: no counter; WAIT holds indefinitely until gen_done; timeout_err is constant 0.

Test Plan:
- Trigger with voice_en=8'hFF, generator answering 1 cycle after each start with sample = 100*(voice+1) -> gen_voice sequence 0..7, mix_out = 3600, mix_valid exactly at T+25, busy low the next cycle.
- Saturation: all 8 voices return 16'sh7000 -> mix_out = 32767. All return -4096 -> mix_out = -32768 exactly, no clipping artifact.
- voice_en=8'h05 with samples 100 (voice 0) and 200 (voice 2) -> only two gen_start pulses (voices 0 and 2), mix_out = 300. voice_en=0 -> zero gen_start pulses, mix_out = 0, mix_valid still pulses.
- Second trigger at T+5 -> ovr_flag = 1, first frame completes normally, no second frame starts. ovr_clr in the same cycle as a new overrun -> ovr_flag stays 1.
- Reset asserted while in WAIT for voice 3 -> all outputs 0 next cycle; a late gen_done is ignored; the next trigger starts cleanly from voice 0.
- With VOICE_SCHED_TIMEOUT_EN, TIMEOUT_CYC=4, voice 2 never answers -> advance after 4 WAIT cycles, timeout_err = 1, mix_out excludes voice 2. Without the macro, the same stimulus keeps the block in WAIT with timeout_err = 0.

Source files
------------

// File: rtl/voice_sched_if.sv
// Handshake bundle between the voice scheduler, its trigger/control source,
// the shared sample generator and the mix consumer.
interface voice_sched_if #(
   parameter int NUM_VOICES = 8,
   parameter int IDX_W      = 3,
   parameter int SMPL_W     = 16
);
   logic                     smpl_rate_trig;
   logic [NUM_VOICES-1:0]    voice_en;
   logic                     gen_start;
   logic [IDX_W-1:0]         gen_voice;
   logic                     gen_done;
   logic signed [SMPL_W-1:0] gen_sample;
   logic signed [SMPL_W-1:0] mix_out;
   logic                     mix_valid;
   logic                     busy;
   logic                     ovr_flag;
   logic                     ovr_clr;
   logic                     timeout_err;

   // Environment side: trigger source, generator and control.
   modport master (
      output smpl_rate_trig, voice_en, gen_done, gen_sample, ovr_clr,
      input  gen_start, gen_voice, mix_out, mix_valid, busy, ovr_flag, timeout_err
   );

   // Scheduler side.
   modport slave (
      input  smpl_rate_trig, voice_en, gen_done, gen_sample, ovr_clr,
      output gen_start, gen_voice, mix_out, mix_valid, busy, ovr_flag, timeout_err
   );
endinterface

// File: rtl/voice_sched.sv
// Per-sample voice scheduler: walks every voice slot through one shared generator
// and emits a saturated mono mix. Define VOICE_SCHED_TIMEOUT_EN for the per-voice wait timeout.
module voice_sched #(
   parameter int NUM_VOICES  = 8,
   parameter int IDX_W       = 3,
   parameter int SMPL_W      = 16,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic          clk,
   input  logic          reset,
   voice_sched_if.slave  bus
);
   localparam int                      ACC_W    = SMPL_W + IDX_W;
   localparam logic signed [ACC_W-1:0] ACC_MAX  = ACC_W'((1 << (SMPL_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] ACC_MIN  = ~ACC_MAX;
   localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_VOICES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_ADV,
      S_OUT
   } state_t;

   generate
      if (NUM_VOICES < 2 || (2 ** IDX_W) < NUM_VOICES || TIMEOUT_CYC < 1) begin : g_bad_param
         $error("voice_sched: illegal parameter combination");
      end
   endgenerate

   state_t                    state_q, state_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic [SMPL_W-1:0]         mix_out_q, mix_out_d;
   logic                      ovr_q, ovr_d;
   logic                      gen_start;

`ifdef VOICE_SCHED_TIMEOUT_EN
   localparam int             CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0]          wait_cnt_q, wait_cnt_d;
   logic                      timeout_q, timeout_d;
`endif

   function automatic logic [SMPL_W-1:0] clip(input logic signed [ACC_W-1:0] a);
      if (a > ACC_MAX)      return ACC_MAX[SMPL_W-1:0];
      else if (a < ACC_MIN) return ACC_MIN[SMPL_W-1:0];
      else                  return a[SMPL_W-1:0];
   endfunction

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d   = state_q;
      idx_d     = idx_q;
      acc_d     = acc_q;
      mix_out_d = mix_out_q;
      gen_start = 1'b0;
`ifdef VOICE_SCHED_TIMEOUT_EN
      wait_cnt_d = wait_cnt_q;
      timeout_d  = timeout_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            if (bus.smpl_rate_trig) begin
               acc_d   = '0;
               idx_d   = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (bus.voice_en[idx_q]) begin
               gen_start = 1'b1;
               state_d   = S_WAIT;
`ifdef VOICE_SCHED_TIMEOUT_EN
               wait_cnt_d = '0;
`endif
            end else begin
               state_d = S_ADV;
            end
         end
         S_WAIT: begin
            // Samples are sign-extended into the wider accumulator so the sum cannot wrap.
            if (bus.gen_done) begin
               acc_d   = acc_q + {{IDX_W{bus.gen_sample[SMPL_W-1]}}, bus.gen_sample};
               state_d = S_ADV;
            end
`ifdef VOICE_SCHED_TIMEOUT_EN
            else if (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               timeout_d = 1'b1;
               state_d   = S_ADV;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
`endif
         end
         S_ADV: begin
            if (idx_q == LAST_IDX) begin
               mix_out_d = clip(acc_q);
               state_d   = S_OUT;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = S_START;
            end
         end
         S_OUT:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // A trigger during OUT also counts as an overrun; set beats clear.
      ovr_d = ovr_q;
      if (bus.smpl_rate_trig && state_q != S_IDLE) ovr_d = 1'b1;
      else if (bus.ovr_clr)                        ovr_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         acc_q     <= '0;
         mix_out_q <= '0;
         ovr_q     <= 1'b0;
`ifdef VOICE_SCHED_TIMEOUT_EN
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         acc_q     <= acc_d;
         mix_out_q <= mix_out_d;
         ovr_q     <= ovr_d;
`ifdef VOICE_SCHED_TIMEOUT_EN
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
`endif
      end
   end

   assign bus.gen_start = gen_start;
   assign bus.gen_voice = idx_q;
   assign bus.mix_out   = mix_out_q;
   assign bus.mix_valid = (state_q == S_OUT);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.ovr_flag  = ovr_q;
`ifdef VOICE_SCHED_TIMEOUT_EN
   assign bus.timeout_err = timeout_q;
`else
   assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_voice_sched.sv
// Self-checking bench for voice_sched: table vectors, randomized frames against a
// sum-and-clip reference model, and hand sequences for overrun, reset and timeout.
module tb_voice_sched;
   localparam int NV = 8;
   localparam int IW = 3;
   localparam int SW = 16;
   localparam int TO = 4;

   typedef logic [NV-1:0][SW-1:0] smp_t;

   typedef struct {
      logic [NV-1:0] en;
      smp_t          smp;
      int            dly;
      int            exp_mix;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   voice_sched_if #(.NUM_VOICES(NV), .IDX_W(IW), .SMPL_W(SW)) bus ();

   voice_sched #(
      .NUM_VOICES (NV),
      .IDX_W      (IW),
      .SMPL_W     (SW),
      .TIMEOUT_CYC(TO)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: the mix is the plain sum of answered, enabled voices, clipped to SW bits.
   function automatic int ref_mix(input logic [NV-1:0] en, input smp_t smp, input logic [NV-1:0] ans);
      int s = 0;
      for (int i = 0; i < NV; i++)
         if (en[i] && ans[i]) s += int'($signed(smp[i]));
      if (s > 32767)  return 32767;
      if (s < -32768) return -32768;
      return s;
   endfunction

   // Reference: trigger-to-mix_valid cycles from the per-voice cost rules.
   function automatic int ref_lat(input logic [NV-1:0] en, input int dly, input logic [NV-1:0] ans);
      int l = 1;
      for (int i = 0; i < NV; i++)
         l += !en[i] ? 2 : (ans[i] ? 2 + dly : 2 + TO);
      return l;
   endfunction

   task automatic run_frame(input string tag, input logic [NV-1:0] en, input smp_t smp,
                            input int dly, input logic [NV-1:0] ans, input int ovr_at,
                            input int clr_at, output int mix);
      int cyc, cd, cur, lat;
      bit done, junk;
      int vq[$];
      int eq[$];
      cyc = 0; cd = 0; cur = 0; lat = -1; done = 0; junk = 0; mix = 0;
      for (int i = 0; i < NV; i++) if (en[i]) eq.push_back(i);
      @(negedge clk);
      bus.voice_en       = en;
      bus.smpl_rate_trig = 1'b1;
      while (!done && cyc < 400) begin
         @(negedge clk);
         cyc++;
         bus.smpl_rate_trig = (cyc == ovr_at);
         bus.ovr_clr        = (cyc == clr_at);
         bus.gen_done       = 1'b0;
         if (junk) begin
            // Stray strobe while the scheduler is advancing; must not be accumulated.
            bus.gen_done   = 1'b1;
            bus.gen_sample = 16'sd777;
            junk = 0;
         end else if (cd > 0) begin
            cd--;
            if (cd == 0 && ans[cur]) begin
               bus.gen_done   = 1'b1;
               bus.gen_sample = smp[cur];
               junk = 1;
            end
         end
         if (bus.gen_start) begin
            vq.push_back(int'(bus.gen_voice));
            cur = int'(bus.gen_voice);
            cd  = dly;
         end
         if (bus.mix_valid) begin
            lat  = cyc;
            mix  = bus.mix_out;
            done = 1;
         end
      end
      check({tag, " mix_out"}, mix, ref_mix(en, smp, ans));
      check({tag, " latency"}, lat, ref_lat(en, dly, ans));
      check({tag, " start_count"}, vq.size(), eq.size());
      for (int k = 0; k < vq.size() && k < eq.size(); k++)
         check($sformatf("%s start_voice%0d", tag, k), vq[k], eq[k]);
      @(negedge clk);
      bus.smpl_rate_trig = 1'b0;
      bus.ovr_clr        = 1'b0;
      bus.gen_done       = 1'b0;
      check({tag, " busy_after"}, bus.busy, 0);
      check({tag, " valid_after"}, bus.mix_valid, 0);
   endtask

   task automatic clear_ovr(input string tag);
      @(negedge clk) bus.ovr_clr = 1'b1;
      @(negedge clk) bus.ovr_clr = 1'b0;
      check({tag, " ovr_cleared"}, bus.ovr_flag, 0);
   endtask

   vec_t tbl[5];
   smp_t smp0, rs;
   int   mix, cyc, cd, cur, starts, mv, extra;

   initial begin
      reset              = 1'b1;
      bus.smpl_rate_trig = 1'b0;
      bus.voice_en       = '0;
      bus.gen_done       = 1'b0;
      bus.gen_sample     = '0;
      bus.ovr_clr        = 1'b0;

      for (int i = 0; i < NV; i++) smp0[i] = 16'(100 * (i + 1));
      tbl[0] = '{en: 8'hFF, smp: smp0, dly: 1, exp_mix: 3600};
      tbl[1] = '{en: 8'hFF, smp: {NV{16'h7000}}, dly: 1, exp_mix: 32767};
      tbl[2] = '{en: 8'hFF, smp: {NV{16'hF000}}, dly: 1, exp_mix: -32768};
      tbl[3] = '{en: 8'h05, smp: {NV{16'd999}}, dly: 1, exp_mix: 300};
      tbl[3].smp[0] = 16'd100;
      tbl[3].smp[2] = 16'd200;
      tbl[4] = '{en: 8'h00, smp: smp0, dly: 1, exp_mix: 0};

      repeat (3) @(negedge clk);
      check("reset gen_start", bus.gen_start, 0);
      check("reset gen_voice", bus.gen_voice, 0);
      check("reset mix_out", bus.mix_out, 0);
      check("reset mix_valid", bus.mix_valid, 0);
      check("reset busy", bus.busy, 0);
      check("reset ovr_flag", bus.ovr_flag, 0);
      check("reset timeout_err", bus.timeout_err, 0);
      reset = 1'b0;

      for (int i = 0; i < 5; i++) begin
         run_frame($sformatf("vec%0d", i), tbl[i].en, tbl[i].smp, tbl[i].dly, 8'hFF, -1, -1, mix);
         check($sformatf("vec%0d table_mix", i), mix, tbl[i].exp_mix);
      end
      check("no spurious overrun", bus.ovr_flag, 0);

      for (int n = 0; n < 24; n++) begin
         for (int i = 0; i < NV; i++) rs[i] = 16'($urandom);
         run_frame($sformatf("rand%0d", n), 8'($urandom), rs, int'($urandom_range(1, 3)), 8'hFF, -1, -1, mix);
      end

      // Overrun mid-frame: frame completes unchanged and no second frame follows.
      run_frame("ovr_mid", 8'hFF, smp0, 1, 8'hFF, 5, -1, mix);
      check("ovr_mid flag", bus.ovr_flag, 1);
      extra = 0;
      repeat (30) @(negedge clk) extra += int'(bus.busy) + int'(bus.gen_start);
      check("ovr_mid no_second_frame", extra, 0);
      clear_ovr("ovr_mid");

      run_frame("ovr_setwins", 8'hFF, smp0, 1, 8'hFF, 6, 6, mix);
      check("ovr_setwins flag", bus.ovr_flag, 1);
      clear_ovr("ovr_setwins");

      run_frame("ovr_out", 8'hFF, smp0, 1, 8'hFF, 25, -1, mix);
      check("ovr_out flag", bus.ovr_flag, 1);
      clear_ovr("ovr_out");

      // Reset while waiting on voice 3.
      @(negedge clk);
      bus.voice_en       = 8'hFF;
      bus.smpl_rate_trig = 1'b1;
      cyc = 0; cd = 0; starts = 0;
      while (starts == 0 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         bus.smpl_rate_trig = 1'b0;
         bus.gen_done       = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               bus.gen_done   = 1'b1;
               bus.gen_sample = 16'sd100;
            end
         end
         if (bus.gen_start) begin
            if (bus.gen_voice == 3'd3) starts = 1;
            else cd = 1;
         end
      end
      check("rst_mid reached_voice3", starts, 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid busy", bus.busy, 0);
      check("rst_mid gen_start", bus.gen_start, 0);
      check("rst_mid gen_voice", bus.gen_voice, 0);
      check("rst_mid mix_out", bus.mix_out, 0);
      check("rst_mid mix_valid", bus.mix_valid, 0);
      reset          = 1'b0;
      bus.gen_done   = 1'b1;
      bus.gen_sample = 16'sd5000;
      @(negedge clk) bus.gen_done = 1'b0;
      extra = 0;
      repeat (10) @(negedge clk) extra += int'(bus.busy) + int'(bus.mix_valid);
      check("rst_mid late_done_ignored", extra, 0);
      run_frame("rst_restart", 8'hFF, smp0, 1, 8'hFF, -1, -1, mix);

`ifdef VOICE_SCHED_TIMEOUT_EN
      run_frame("timeout", 8'hFF, smp0, 1, 8'hFB, -1, -1, mix);
      check("timeout mix_excludes_v2", mix, 3300);
      check("timeout err_set", bus.timeout_err, 1);
`else
      @(negedge clk);
      bus.voice_en       = 8'hFF;
      bus.smpl_rate_trig = 1'b1;
      cd = 0; cur = 0; starts = 0; mv = 0;
      repeat (60) begin
         @(negedge clk);
         bus.smpl_rate_trig = 1'b0;
         bus.gen_done       = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0 && cur != 2) begin
               bus.gen_done   = 1'b1;
               bus.gen_sample = 16'sd100;
            end
         end
         if (bus.gen_start) begin
            cur = int'(bus.gen_voice);
            cd  = 1;
            starts++;
         end
         mv += int'(bus.mix_valid);
      end
      check("notimeout busy_held", bus.busy, 1);
      check("notimeout gen_voice", bus.gen_voice, 2);
      check("notimeout starts", starts, 3);
      check("notimeout no_mix", mv, 0);
      check("notimeout err_zero", bus.timeout_err, 0);
      reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      check("notimeout reset_idle", bus.busy, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
